// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the core's instruction memory.
// Accepts a 16-bit little-endian word count followed by that many little-endian
// 32-bit words, one byte per valid/ready handshake. Each word is written to
// consecutive word addresses starting at 0. The core is held in reset until
// the last word has been written.
// Ports:
//   clk, reset        - clock; asynchronous active-high reset
//   byte_valid/_data  - incoming byte stream
//   byte_ready        - loader can take a byte (decoded from state)
//   mem_we/addr/wdata - one-cycle instruction-memory write per word
//   core_reset        - held high until the load completes
//   done, error       - sticky completion / capacity-overflow flags
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_reset,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned WIDX_W   = ADDR_WIDTH + 1;
    localparam int unsigned CAPACITY = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_CNT0,
        S_CNT1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [1:0]            bidx_q, bidx_d;
    logic [31:0]           word_q, word_d;
    logic [WIDX_W-1:0]     widx_q, widx_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  core_reset_q, core_reset_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic                  accept;
    logic [15:0]           full_count;

    // Only byte_ready is combinational; it follows the state register.
    assign byte_ready = (state_q == S_CNT0) || (state_q == S_CNT1) || (state_q == S_DATA);
    assign accept     = byte_valid && byte_ready;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_CNT0;
            count_q      <= '0;
            bidx_q       <= '0;
            word_q       <= '0;
            widx_q       <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            bidx_q       <= bidx_d;
            word_q       <= word_d;
            widx_q       <= widx_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        bidx_d      = bidx_q;
        word_d      = word_q;
        widx_d      = widx_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        full_count  = {byte_data, count_q[7:0]};

        case (state_q)
            S_CNT0: begin
                if (accept) begin
                    count_d[7:0] = byte_data;
                    state_d      = S_CNT1;
                end
            end
            S_CNT1: begin
                if (accept) begin
                    count_d = full_count;
                    if (full_count == 16'd0) begin
                        state_d = S_DONE;
                    end else if (32'(full_count) > CAPACITY) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d[{bidx_q, 3'b000} +: 8] = byte_data;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        // Latch the write payload so mem_we/addr/wdata line up in WRITE.
                        state_d     = S_WRITE;
                        mem_addr_d  = widx_q[ADDR_WIDTH-1:0];
                        mem_wdata_d = {byte_data, word_q[23:0]};
                    end
                end
            end
            S_WRITE: begin
                widx_d = widx_q + WIDX_W'(1);
                if ((32'(widx_q) + 32'd1) == 32'(count_q)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_CNT0;
            end
        endcase

        // Registered outputs reflect the state being entered.
        mem_we_d     = (state_d == S_WRITE);
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERR);
        core_reset_d = (state_d != S_DONE);
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_reset = core_reset_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader (ADDR_WIDTH = 8).
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_reset;
    logic        done;
    logic        error;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          n_writes = 0;
    logic [39:0] exp_q[$];
    logic [7:0]  stream[$];

    imem_loader #(.ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every mem_we pulse must match the next expected write.
    always @(negedge clk) begin
        if (!reset && mem_we) begin
            n_writes++;
            check("ready_low_in_write", 32'(byte_ready), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                check("write_addr", 32'(mem_addr), 32'(e[39:32]));
                check("write_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic check_reset_values();
        check("rst_byte_ready", 32'(byte_ready), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        byte_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Assert reset between edges and check outputs before any edge arrives.
    task automatic async_reset();
        @(negedge clk);
        byte_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_values();
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input bit gap, output int acc_cyc);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc_cyc = -1;
        if (!byte_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            acc_cyc = cyc;
        end
        if (gap) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_stream(input bit gap, output int first_cyc);
        int c;
        first_cyc = -1;
        foreach (stream[i]) begin
            send_byte(stream[i], gap, c);
            if (i == 0) first_cyc = c;
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(output int done_cyc);
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        done_cyc = cyc;
        check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic load_normal_stream();
        stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h00, 8'h00};
        exp_q.push_back({8'h00, 32'h0000_0013});
        exp_q.push_back({8'h01, 32'h0000_00B3});
    endtask

    initial begin
        int first_c;
        int done_c;
        int c;
        int w0;
        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #3;
        check_reset_values();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Normal load with byte_valid held high.
        load_normal_stream();
        w0 = n_writes;
        foreach (stream[i]) begin
            send_byte(stream[i], 1'b0, c);
            if (i == 0) first_c = c;
        end
        // Held-high valid during the final WRITE must not be consumed.
        check("last_write_pulse", 32'(mem_we), 32'd1);
        check("done_before_final_edge", 32'(done), 32'd0);
        check("core_reset_before_final_edge", 32'(core_reset), 32'd1);
        @(negedge clk);
        done_c = cyc;
        check("normal_done", 32'(done), 32'd1);
        check("normal_core_reset", 32'(core_reset), 32'd0);
        check("normal_done_latency", 32'(done_c - first_c), 32'd11);
        check("normal_write_count", 32'(n_writes - w0), 32'd2);
        check("normal_missing_writes", 32'(exp_q.size()), 32'd0);

        // Bytes after DONE are ignored.
        byte_valid = 1'b1;
        byte_data  = 8'hFF;
        repeat (3) @(negedge clk);
        check("post_done_ready", 32'(byte_ready), 32'd0);
        check("post_done_done", 32'(done), 32'd1);
        check("post_done_core_reset", 32'(core_reset), 32'd0);
        check("post_done_addr_hold", 32'(mem_addr), 32'd1);
        check("post_done_data_hold", mem_wdata, 32'h0000_00B3);
        check("post_done_no_write", 32'(n_writes - w0), 32'd2);

        // Asynchronous reset from DONE with non-zero outputs.
        async_reset();

        // Zero count.
        w0 = n_writes;
        stream = '{8'h00, 8'h00};
        send_stream(1'b0, first_c);
        check("zero_done", 32'(done), 32'd1);
        check("zero_core_reset", 32'(core_reset), 32'd0);
        repeat (2) @(negedge clk);
        check("zero_no_write", 32'(n_writes - w0), 32'd0);

        // Overflow: N = 257.
        do_reset();
        w0 = n_writes;
        stream = '{8'h01, 8'h01};
        send_stream(1'b0, first_c);
        check("ovf_error", 32'(error), 32'd1);
        check("ovf_ready", 32'(byte_ready), 32'd0);
        check("ovf_core_reset", 32'(core_reset), 32'd1);
        check("ovf_done", 32'(done), 32'd0);
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (4) @(negedge clk);
        byte_valid = 1'b0;
        check("ovf_error_sticky", 32'(error), 32'd1);
        check("ovf_no_write", 32'(n_writes - w0), 32'd0);

        // Full capacity: N = 256, last write to 0xFF.
        do_reset();
        w0 = n_writes;
        stream = '{8'h00, 8'h01};
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            stream.push_back(b);
            stream.push_back(~b);
            stream.push_back(8'h3C);
            stream.push_back(b ^ 8'h5A);
            exp_q.push_back({b, b ^ 8'h5A, 8'h3C, ~b, b});
        end
        send_stream(1'b0, first_c);
        wait_done(done_c);
        check("cap_write_count", 32'(n_writes - w0), 32'd256);
        check("cap_last_addr", 32'(mem_addr), 32'hFF);
        check("cap_last_data", mem_wdata, 32'hA53C_00FF);
        check("cap_error", 32'(error), 32'd0);
        check("cap_missing_writes", 32'(exp_q.size()), 32'd0);

        // Stalled stream: byte_valid toggles every cycle.
        do_reset();
        w0 = n_writes;
        load_normal_stream();
        send_stream(1'b1, first_c);
        wait_done(done_c);
        check("stall_later", 32'(done_c - first_c > 11), 32'd1);
        check("stall_write_count", 32'(n_writes - w0), 32'd2);
        check("stall_missing_writes", 32'(exp_q.size()), 32'd0);

        // Reset mid-load after 2nd data byte of word 0, then a fresh stream.
        do_reset();
        w0 = n_writes;
        stream = '{8'h02, 8'h00, 8'h13, 8'h00};
        send_stream(1'b0, first_c);
        async_reset();
        stream = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        exp_q.push_back({8'h00, 32'hDEAD_BEEF});
        send_stream(1'b0, first_c);
        wait_done(done_c);
        check("midrst_write_count", 32'(n_writes - w0), 32'd1);
        check("midrst_missing_writes", 32'(exp_q.size()), 32'd0);
        check("midrst_core_reset", 32'(core_reset), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader sitting directly upstream of the RISC-V core's instruction memory. It receives a length-prefixed program image one byte per handshake, assembles little-endian 32-bit instruction words, and writes them into consecutive instruction-memory word addresses starting at 0. While loading, it holds the core in reset. It releases the core only after the last word has been written. It replaces back-door memory preloading with a synthesizable load path.

## Interface
Parameters:
- ADDR_WIDTH, default 8: instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- byte_valid  input  1  byte_data holds a valid byte.
- byte_data  input  8  program byte.
- byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  ADDR_WIDTH  word address of the write.
- mem_wdata  output  32  assembled instruction word.
- core_reset  output  1  reset to the core, high until the load completes.
- done  output  1  load finished successfully; sticky until reset.
- error  output  1  word count exceeds capacity; sticky until reset.

## Operation
- Stream format: 2-byte word count N (LSB first), then N×4 bytes, each word least-significant byte first.
- States:
  - CNT0 (reset state): capture count[7:0].
  - CNT1: capture count[15:8].
  - DATA: collect bytes into word.
  - WRITE: issue the memory write.
  - DONE: load complete.
  - ERR: capacity exceeded.
- CNT0 → CNT1 on accepted byte.
- CNT1 on accepted byte, using the full 16-bit count:
  - N == 0 → DONE.
  - N > 2^ADDR_WIDTH → ERR.
  - Otherwise → DATA.
- DATA: a 2-bit byte index selects the word lane (index 0 → bits [7:0], … index 3 → [31:24]). The 4th accepted byte → WRITE, with the index wrapped to 0.
- WRITE: mem_we=1 for exactly one cycle, with mem_addr = current word index and mem_wdata = assembled word.
  - Word index increments after the write.
  - If the words written now equal N → DONE; else → DATA.
- DONE: done=1, core_reset=0. Remains in DONE until reset; further bytes are ignored.
- ERR: error=1, core_reset stays 1. Remains in ERR until reset.
- byte_ready = 1 in CNT0, CNT1 and DATA; 0 in WRITE, DONE and ERR. Bytes presented while byte_ready=0 are not consumed.
- Word-index counter width is ADDR_WIDTH+1, so exactly 2^ADDR_WIDTH words is legal; the last write goes to address 2^ADDR_WIDTH−1.
- Reset mid-load (asynchronous):
  - State → CNT0; counters and word register cleared.
  - core_reset=1, done=0, error=0, mem_we=0 immediately.
  - Partially written memory contents are not erased; a new stream starts from its count bytes.

## Timing
- All outputs are registered except byte_ready, which is decoded from the state register.
- Reset values: byte_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, core_reset=1, done=0, error=0.
- Per-word cost is a minimum of 5 cycles: 4 byte cycles plus 1 WRITE cycle.
- mem_we asserts in the cycle after the 4th byte of a word is accepted.
- done rises and core_reset falls:
  - for N>0, on the edge that ends the final WRITE cycle (the cycle after the last mem_we);
  - for N=0, on the edge that accepts the second count byte.
- Gaps in byte_valid stall progress with no state change; there is no timeout.
- mem_addr and mem_wdata hold their last values when mem_we=0.

## Test plan
- Normal load:
  - Stimulus: bytes 02 00 13 00 00 00 B3 00 00 00, byte_valid held high.
  - Required: mem_we pulses twice, first with addr 0 / data 0x00000013, then with addr 1 / data 0x000000B3.
  - Required: byte_ready low in each WRITE cycle.
  - Required: core_reset falls and done rises on the edge ending the 2nd write cycle, 11 cycles after the first byte.
- Zero count:
  - Stimulus: bytes 00 00.
  - Required: done=1 and core_reset=0 on the next edge; no mem_we.
- Overflow with ADDR_WIDTH=8:
  - Stimulus: count bytes 01 01 (N=257).
  - Required: error=1, byte_ready=0, core_reset stays 1, no writes.
  - Stimulus: count bytes 00 01 (N=256).
  - Required: accepted; the final write goes to addr 0xFF.
- Stalled stream:
  - Stimulus: same stream as the normal load, with byte_valid toggling 1/0 every cycle.
  - Required: identical writes and data; done arrives later; no byte is skipped or duplicated.
- Reset mid-load:
  - Stimulus: assert reset asynchronously between clock edges after the 2nd data byte of word 0; release it, then send stream 01 00 EF BE AD DE.
  - Required: outputs return to reset values without waiting for a clock edge.
  - Required: single write of addr 0 / data 0xDEADBEEF, then done=1.
- Ignored bytes:
  - Stimulus: byte_valid=1 during WRITE and after DONE.
  - Required: those bytes are not consumed (byte_ready=0); state and outputs unchanged.
